// File: rtl/pipeline_flow_ctrl.sv
// Pipeline hazard/flow controller: stage enables and flushes from the current state and inputs.
// Debug halt drains EX/MEM/WB before HALTED; step issues one instruction then re-drains.
module pipeline_flow_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_busy_i,
    input  logic             dbg_halt_req_i,
    input  logic             dbg_resume_req_i,
    input  logic             dbg_step_req_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_we_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_we_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_we_o,
    output logic             mem_wb_flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    // Extra headroom keeps the width non-zero even for DRAIN_CYCLES = 0.
    localparam int DW = $clog2(DRAIN_CYCLES + 2);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          load_use;
    logic          stall_evt;

    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        pc_we_o        = 1'b1;
        if_id_we_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_we_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_we_o    = 1'b1;
        ex_mem_flush_o = 1'b0;
        mem_wb_we_o    = 1'b1;
        mem_wb_flush_o = 1'b0;
        halted_o       = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (ex_busy_i) begin
                    pc_we_o        = 1'b0;
                    if_id_we_o     = 1'b0;
                    id_ex_we_o     = 1'b0;
                    ex_mem_we_o    = 1'b0;
                    ex_mem_flush_o = 1'b1;
                end else if (ex_branch_taken_i) begin
                    if_id_flush_o  = 1'b1;
                    id_ex_flush_o  = 1'b1;
                end else if (load_use) begin
                    pc_we_o        = 1'b0;
                    if_id_we_o     = 1'b0;
                    id_ex_flush_o  = 1'b1;
                end
            end
            ST_DRAIN: begin
                // ID keeps its instruction so it is the first one issued on resume.
                if_id_we_o = 1'b0;
                if (ex_busy_i) begin
                    pc_we_o        = 1'b0;
                    id_ex_we_o     = 1'b0;
                    ex_mem_we_o    = 1'b0;
                    ex_mem_flush_o = 1'b1;
                end else begin
                    pc_we_o        = ex_branch_taken_i;
                    if_id_flush_o  = ex_branch_taken_i;
                    id_ex_flush_o  = 1'b1;
                end
            end
            ST_HALTED: begin
                pc_we_o     = 1'b0;
                if_id_we_o  = 1'b0;
                id_ex_we_o  = 1'b0;
                ex_mem_we_o = 1'b0;
                mem_wb_we_o = 1'b0;
                halted_o    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        unique case (state)
            ST_RUN: begin
                if (dbg_halt_req_i) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!ex_busy_i) begin
                    if (drain_cnt <= DW'(1)) begin
                        state_nxt     = ST_HALTED;
                        drain_cnt_nxt = '0;
                    end else begin
                        drain_cnt_nxt = drain_cnt - DW'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (dbg_resume_req_i)
                    state_nxt = ST_RUN;
                else if (dbg_step_req_i)
                    state_nxt = ST_STEP;
            end
            default: begin
                state_nxt     = ST_DRAIN;
                drain_cnt_nxt = DRAIN_LOAD;
            end
        endcase
    end

    // A load-use that loses to a redirect is not a stall.
    assign stall_evt = (state == ST_RUN) &&
                       (ex_busy_i || (!ex_branch_taken_i && load_use));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (stall_evt && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (if_id_flush_o && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: RUN-mode vector table plus debug, reset and saturation sequences.
module tb_pipeline_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, br, busy, halt, resume, stepq;
    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic        ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic [8:0]  outs;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // Output bit order: pc, if_id_we, if_id_fl, id_ex_we, id_ex_fl, ex_mem_we, ex_mem_fl, mem_wb_we, mem_wb_fl
    localparam logic [8:0] O_DEF   = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] O_BUSY  = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] O_BR    = 9'b1_1_1_1_1_1_0_1_0;
    localparam logic [8:0] O_LU    = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] O_DRN   = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] O_DRNBR = 9'b1_0_1_1_1_1_0_1_0;
    localparam logic [8:0] O_HLT   = 9'b0_0_0_0_0_0_0_0_0;

    pipeline_flow_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .ex_rd_i(rd), .ex_mem_read_i(mr),
        .ex_branch_taken_i(br), .ex_busy_i(busy),
        .dbg_halt_req_i(halt), .dbg_resume_req_i(resume), .dbg_step_req_i(stepq),
        .pc_we_o(pc_we),
        .if_id_we_o(if_id_we), .if_id_flush_o(if_id_flush),
        .id_ex_we_o(id_ex_we), .id_ex_flush_o(id_ex_flush),
        .ex_mem_we_o(ex_mem_we), .ex_mem_flush_o(ex_mem_flush),
        .mem_wb_we_o(mem_wb_we), .mem_wb_flush_o(mem_wb_flush),
        .halted_o(halted),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                   ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush};

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       mr, br, busy;
        logic [8:0] exp;
        int         ds, df;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                          input logic [4:0] d, input logic m, input logic bt, input logic bz);
        rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; mr = m; br = bt; busy = bz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        halt = 1'b0; resume = 1'b0; stepq = 1'b0;
    endtask

    task automatic cyc_check(input string nm, input logic [8:0] e, input logic eh);
        @(negedge clk);
        chk(nm, 32'(outs), 32'(e));
        chk({nm, "_halted"}, 32'(halted), 32'(eh));
        tick();
    endtask

    task automatic chk_cnt(input string nm);
        @(negedge clk);
        chk({nm, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        chk({nm, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic ua,
                                input logic ub, input logic [4:0] d, input logic m,
                                input logic bt, input logic bz, input logic [8:0] e,
                                input int ds, input int df);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.u1 = ua; v.u2 = ub; v.rd = d;
        v.mr = m; v.br = bt; v.busy = bz; v.exp = e; v.ds = ds; v.df = df;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_DEF,  0, 0);
        vecs[1]  = mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, O_LU,   1, 0);
        vecs[2]  = mk(5'd1, 5'd0, 0, 1, 5'd0, 1, 0, 0, O_DEF,  0, 0);
        vecs[3]  = mk(5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 0, O_DEF,  0, 0);
        vecs[4]  = mk(5'd7, 5'd2, 1, 1, 5'd7, 1, 0, 0, O_LU,   1, 0);
        vecs[5]  = mk(5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, O_DEF,  0, 0);
        vecs[6]  = mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, O_BR,   0, 1);
        vecs[7]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_BR,   0, 1);
        vecs[8]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, O_BUSY, 1, 0);
        vecs[9]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, O_BUSY, 1, 0);
        vecs[10] = mk(5'd9, 5'd3, 1, 1, 5'd9, 1, 0, 0, O_LU,   1, 0);

        rst_n = 1'b0;
        halt = 1'b0; resume = 1'b0; stepq = 1'b0;
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        #12;
        chk("reset_outs", 32'(outs), 32'(O_DEF));
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                   vecs[i].rd, vecs[i].mr, vecs[i].br, vecs[i].busy);
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(exp_stall));
            chk($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), 32'(exp_flush));
            exp_stall += vecs[i].ds;
            exp_flush += vecs[i].df;
            tick();
        end
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        chk_cnt("table_end");
        tick();

        // Redirect held back by a 3-cycle busy op, applied on the first free cycle.
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc_check($sformatf("busy_br%0d", i), O_BUSY, 0);
        exp_stall += 3;
        busy = 1'b0;
        cyc_check("redirect", O_BR, 0);
        exp_flush += 1;
        br = 1'b0;
        chk_cnt("busy_br");
        tick();

        // Halt with one busy cycle inside DRAIN: HALTED five cycles after the pulse.
        halt = 1'b1;
        cyc_check("halt_pulse", O_DEF, 0);
        cyc_check("drain_a", O_DRN, 0);
        busy = 1'b1;
        cyc_check("drain_busy", O_BUSY, 0);
        busy = 1'b0; br = 1'b1;
        cyc_check("drain_br", O_DRNBR, 0);
        exp_flush += 1;
        br = 1'b0;
        cyc_check("drain_b", O_DRN, 0);
        cyc_check("halted_entry", O_HLT, 1);
        busy = 1'b1; halt = 1'b1;
        cyc_check("halted_busy", O_HLT, 1);
        busy = 1'b0;
        cyc_check("halted_hold", O_HLT, 1);
        chk_cnt("halted");
        tick();

        // Step and resume together: resume wins.
        resume = 1'b1; stepq = 1'b1;
        cyc_check("halted_sr", O_HLT, 1);
        cyc_check("resume_run", O_DEF, 0);
        halt = 1'b1;
        cyc_check("halt2_pulse", O_DEF, 0);
        for (int i = 0; i < 3; i++) cyc_check($sformatf("drain2_%0d", i), O_DRN, 0);
        cyc_check("halted2", O_HLT, 1);
        stepq = 1'b1;
        cyc_check("step_req", O_HLT, 1);
        cyc_check("step_cycle", O_DEF, 0);
        for (int i = 0; i < 3; i++) cyc_check($sformatf("step_drain%0d", i), O_DRN, 0);
        cyc_check("step_halted", O_HLT, 1);
        resume = 1'b1;
        cyc_check("resume_req", O_HLT, 1);
        cyc_check("resume2_run", O_DEF, 0);

        // Reset in the middle of a drain abandons the halt.
        halt = 1'b1;
        cyc_check("halt3_pulse", O_DEF, 0);
        cyc_check("drain3_a", O_DRN, 0);
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk("rst_drain_outs", 32'(outs), 32'(O_DEF));
        chk("rst_drain_halted", 32'(halted), 32'd0);
        chk("rst_drain_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_drain_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc_check($sformatf("post_rst%0d", i), O_DEF, 0);

        // Stall counter saturation.
        busy = 1'b1;
        repeat (65535) tick();
        @(negedge clk);
        chk("stall_sat_reach", 32'(stall_cnt), 32'hFFFF);
        tick();
        @(negedge clk);
        chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);
        chk("stall_sat_flush_cnt", 32'(flush_cnt), 32'd0);
        busy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
